mux2_rr_arbiter: RTL
====================

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, width of each data channel.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a_valid  input  1  requester A beat valid.
REQ-005 a_ready  output  1  requester A beat accepted when a_valid && a_ready.
REQ-006 a_data  input  DATA_W  requester A payload.
REQ-007 a_last  input  1  marks final beat of A packet.
REQ-008 b_valid / b_ready / b_data / b_last: same as REQ-004..007 for requester B.
REQ-009 y_valid  output  1  output stage holds a beat.
REQ-010 y_ready  input  1  downstream accepts when y_valid && y_ready.
REQ-011 y_data  output  DATA_W  registered muxed payload.
REQ-012 y_last  output  1  registered last flag of the beat in y_data.
REQ-013 sel  output  1  mux select: 0 = A, 1 = B; drives the shared 2:1 datapath.

Function
REQ-014 States: IDLE, LOCK_A, LOCK_B; lg register records the last requester granted.
REQ-015 out_free = !y_valid || y_ready; no input beat is accepted unless out_free.
REQ-016 IDLE grant: only A valid -> A; only B valid -> B; both valid -> requester other than lg; none -> no grant.
REQ-017 sel = current grant; in IDLE with no request, sel = lg; in LOCK_x, sel = x.
REQ-018 Only the granted requester's ready may be high; ready = granted && out_free; the ungranted ready is 0.
REQ-019 On accepted beat: y_data/y_last load the granted data/last next edge, y_valid = 1 (latency 1 cycle).
REQ-020 If y_valid && y_ready and no beat is accepted that cycle, y_valid clears next edge.
REQ-021 Accepted beat with last = 0 from IDLE -> LOCK_x; with last = 1 -> stay IDLE.
REQ-022 In LOCK_x: other requester is ignored regardless of its valid; accepted last beat -> IDLE.
REQ-023 lg updates to x only when x's last beat is accepted; packets are never interleaved.
REQ-024 Single-beat packets (last = 1 on first beat) from both sides alternate A,B,A,B under continuous contention.
REQ-025 y_ready low with y_valid high: y_data, y_last, y_valid hold; both readies low.
REQ-026 Input valid dropping mid-packet in LOCK_x: remain in LOCK_x, no beat transferred, no re-arbitration.
REQ-027 Full throughput: with y_ready held high, one beat per cycle is sustained.

Reset
REQ-028 While rst high at an edge: state = IDLE, lg = 1 (B), y_valid = 0, y_data = 0, y_last = 0.
REQ-029 Reset during LOCK_x abandons the packet; the first post-reset tie grants A.
REQ-030 a_ready and b_ready are 0 during any cycle in which rst is high.

Structure
REQ-031 Package mux2_arb_pkg holds the state enum (IDLE, LOCK_A, LOCK_B) and the DATA_W default constant.
REQ-032 Datapath select shall be a sub-module mux2_dp (DATA_W-wide 2:1 mux, select = sel); arbitration FSM and output register stay in mux2_rr_arbiter.

Verification
REQ-033 Reset, then a_valid=1,a_data=8'h11,a_last=1, y_ready=1 -> a_ready=1 same cycle, y_valid=1, y_data=8'h11 next cycle.
REQ-034 Both valid, single-beat packets, a_data=8'hA0.., b_data=8'hB0.., y_ready=1 for 6 cycles -> y_data sequence A,B,A,B,A,B starting with A.
REQ-035 A sends 3-beat packet (8'h01,02,03, last on 03) while b_valid=1 throughout -> b_ready=0 until 8'h03 accepted, then B granted next cycle; sel=0 during A packet.
REQ-036 y_ready=0 for 4 cycles with y_valid=1, y_data=8'h5A -> y_data stable 8'h5A, a_ready=b_ready=0; y_ready=1 -> transfer resumes next cycle.
REQ-037 rst=1 asserted in LOCK_B after 1 of 3 beats -> next cycle y_valid=0, state IDLE; tie afterwards grants A.
REQ-038 a_valid drops for 2 cycles mid-packet while b_valid=1 -> no B beat accepted, sel stays 0, packet completes when a_valid returns.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_arb_pkg
//  Purpose  : Shared types and constants for the two-input round-robin
//             packet arbiter (state encoding, default payload width).
//  Revision : 1.0 - initial release
// ============================================================================
package mux2_arb_pkg;

  // Default width of each payload channel.
  localparam int C_DATA_W_DEFAULT = 8;

  // Arbiter states. LOCK_x holds the grant on requester x until its last beat.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mux2_dp.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_dp
//  Purpose  : Shared DATA_W-wide 2:1 datapath multiplexer.
//  Ports    : sel - 0 selects a, 1 selects b
//             a   - input word from requester A
//             b   - input word from requester B
//             y   - selected word
//  Revision : 1.0 - initial release
// ============================================================================
module mux2_dp
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W = C_DATA_W_DEFAULT
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? b : a;

endmodule
`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_rr_arbiter
//  Purpose  : Two-requester round-robin packet arbiter feeding one registered
//             output stage. A packet, once started, owns the output until its
//             last beat is accepted; ties in IDLE go to the requester that was
//             not granted last.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             a_valid/a_ready/a_data/a_last - requester A stream
//             b_valid/b_ready/b_data/b_last - requester B stream
//             y_valid/y_ready/y_data/y_last - registered output stream
//             sel                 - current mux select (0 = A, 1 = B)
//  Revision : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W = C_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  output logic              sel
);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic              r_lg;          // last requester granted: 0 = A, 1 = B
  logic              w_lg_next;
  logic              w_gnt_any;     // some requester currently holds the grant
  logic              w_sel;
  logic              w_out_free;
  logic              w_gnt_valid;
  logic              w_accept;
  logic [DATA_W:0]   w_mux_out;     // {last, data} of the selected requester

  // Output stage can take a new beat when empty or draining this cycle.
  assign w_out_free = !y_valid || y_ready;

  // Grant / select decision.
  always_comb begin
    w_gnt_any = 1'b0;
    w_sel     = r_lg;
    case (r_state)
      LOCK_A: begin
        w_gnt_any = 1'b1;
        w_sel     = 1'b0;
      end
      LOCK_B: begin
        w_gnt_any = 1'b1;
        w_sel     = 1'b1;
      end
      default: begin
        if (a_valid && b_valid) begin
          w_gnt_any = 1'b1;
          w_sel     = !r_lg;        // tie goes to the one not granted last
        end else if (a_valid) begin
          w_gnt_any = 1'b1;
          w_sel     = 1'b0;
        end else if (b_valid) begin
          w_gnt_any = 1'b1;
          w_sel     = 1'b1;
        end
      end
    endcase
  end

  // In LOCK_x the grant is held even while x's valid is low, so ready may be
  // high without a transfer; the locked packet simply waits.
  assign w_gnt_valid = w_sel ? b_valid : a_valid;
  assign a_ready     = w_gnt_any && !w_sel && w_out_free && !rst;
  assign b_ready     = w_gnt_any &&  w_sel && w_out_free && !rst;
  assign w_accept    = w_gnt_any && w_gnt_valid && w_out_free && !rst;
  assign sel         = w_sel;

  mux2_dp #(
    .DATA_W (DATA_W + 1)
  ) u_dp (
    .sel (w_sel),
    .a   ({a_last, a_data}),
    .b   ({b_last, b_data}),
    .y   (w_mux_out)
  );

  // Next-state: a non-last beat locks the grant, a last beat releases it and
  // records the winner for the next tie.
  always_comb begin
    w_state_next = r_state;
    w_lg_next    = r_lg;
    if (w_accept) begin
      if (w_mux_out[DATA_W]) begin
        w_state_next = IDLE;
        w_lg_next    = w_sel;
      end else begin
        w_state_next = w_sel ? LOCK_B : LOCK_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lg    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_lg    <= w_lg_next;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
    end else if (w_accept) begin
      y_valid <= 1'b1;
      y_data  <= w_mux_out[DATA_W-1:0];
      y_last  <= w_mux_out[DATA_W];
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
